pipelined_sequential_subtractor: RTL and testbench
==================================================

// Module: pipelined_sequential_subtractor
// PURPOSE
//   Computes d = a - b - bin over WIDTH bits, sliced into STAGES ripple-borrow slices.
//   One slice is evaluated per pipeline stage; the borrow is registered between stages.
//   Sustains one operation per clock, with valid/ready handshakes on both sides.
//   Companion datapath to pipelined_sequential_adder; drops into the same ALU pipeline.
// PARAMETERS
//   WIDTH   32  operand/result width; must be divisible by STAGES
//   STAGES   4  number of borrow slices/stages; slice width SW = WIDTH/STAGES
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rstn       in   1      asynchronous, active-low reset
//   a          in   WIDTH  minuend (unsigned or two's complement)
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in into slice 0
//   valid_in   in   1      a/b/bin valid this cycle
//   ready_in   out  1      block accepts input this cycle
//   d          out  WIDTH  difference, registered
//   bout       out  1      borrow-out of MSB slice (1 iff a < b + bin, unsigned)
//   ovf        out  1      signed overflow
//   zero       out  1      d == 0
//   valid_out  out  1      d/bout/ovf/zero valid
//   ready_out  in   1      downstream accepts the result this cycle
// BEHAVIOUR
//   - Reset (rstn=0, async): d, bout, ovf, zero, valid_out and all stage valids = 0.
//     All operand, partial-difference and borrow registers = 0. ready_in = 1 once released.
//   - Reset mid-operation: every in-flight op is discarded; no valid_out after release
//     until new inputs are accepted.
//   - Accept: an input transfers on any edge with valid_in && ready_in.
//     It is captured with its valid bit into stage 0.
//   - Stage i (0..STAGES-1): computes slice i: {b_i, d[SW*i +: SW]} = a_slice - b_slice - brw_i.
//     brw_0 = registered bin; brw_i = registered borrow from stage i-1.
//     Lower result slices already computed shift forward unchanged with the op.
//     Upper operand slices also shift forward unchanged.
//   - Output register: loads the full d, bout = borrow of slice STAGES-1, and the flags.
//     ovf  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]).
//     zero = (d == 0).
//   - Latency: STAGES+1 cycles, accept edge to the edge asserting valid_out (5 at default).
//     Throughput is 1 op/cycle when ready_out = 1.
//   - Backpressure: stall = valid_out && !ready_out.
//     ready_in = !stall (combinational).
//     When stalled, every stage register and the output register hold.
//     d/bout/ovf/zero/valid_out stay stable until the transfer.
//   - No stall when valid_out = 0 (empty output slot). Bubbles travel with the pipeline
//     and are not collapsed.
//   - Simultaneous output transfer and input accept in one cycle is legal:
//     the pipeline advances and the new op enters stage 0.
//   - valid_in while ready_in = 0: the input is ignored; upstream must hold it.
//   - Results leave in acceptance order. No op is lost or duplicated.
//   - Width rules: all arithmetic is modulo 2^WIDTH; bin is treated as a 1-bit unsigned value.
// TESTING
//   1. 0x0000_0005 - 0x0000_0003, bin=0 -> d=0x0000_0002, bout=0, ovf=0, zero=0,
//      valid_out exactly 5 cycles after accept.
//   2. 0x0000_0000 - 0x0000_0001 -> d=0xFFFF_FFFF, bout=1, ovf=0;
//      0x0000_0100 - 0x0000_0001 -> d=0x0000_00FF, bout=0 (borrow crosses stage boundary).
//   3. 0x8000_0000 - 0x0000_0001 -> d=0x7FFF_FFFF, ovf=1, bout=0;
//      0x7FFF_FFFF - 0xFFFF_FFFF -> d=0x8000_0000, ovf=1, bout=1.
//   4. 0x1234_5678 - 0x1234_5677, bin=1 -> d=0, zero=1, bout=0.
//   5. Stream of 10 back-to-back random ops; ready_out=0 for 3 cycles mid-stream.
//      -> ready_in low during the stall, outputs held stable, all 10 results match the
//      model in order, none lost.
//   6. Assert rstn=0 with 3 ops in flight -> outputs 0 immediately (async).
//      After release: no valid_out until a new accept, then correct result 5 cycles later.

Source files
------------

// File: rtl/pipelined_sequential_subtractor_if.sv
// Handshake bundle for the pipelined subtractor: operand side (a/b/bin with
// valid_in/ready_in) and result side (d and flags with valid_out/ready_out).
interface pipelined_sequential_subtractor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             valid_out;
  logic             ready_out;

  // Environment side: supplies operands and consumes results.
  modport master (
    output a, b, bin, valid_in, ready_out,
    input  ready_in, d, bout, ovf, zero, valid_out
  );

  // Datapath side.
  modport slave (
    input  a, b, bin, valid_in, ready_out,
    output ready_in, d, bout, ovf, zero, valid_out
  );
endinterface

// File: rtl/pipelined_sequential_subtractor.sv
// Pipelined ripple-borrow subtractor: d = a - b - bin, one SW-bit slice per
// stage with the borrow registered between stages. Stage 0 holds the captured
// operands; stage k+1 holds the op after slice k has been resolved; a final
// output register adds the flags. Whole pipe freezes while the output slot is
// full and not taken.
module pipelined_sequential_subtractor #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rstn,
  pipelined_sequential_subtractor_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  // Slice subtract; MSB of the result is the borrow out of the slice.
  function automatic logic [SW:0] slice_sub(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          bi);
    return {1'b0, x} - {1'b0, y} - {{SW{1'b0}}, bi};
  endfunction

  // Per-stage state, index = stage number (0..STAGES).
  logic [WIDTH-1:0] a_p   [0:STAGES];
  logic [WIDTH-1:0] b_p   [0:STAGES];
  logic [WIDTH-1:0] d_p   [0:STAGES];
  logic             brw_p [0:STAGES];
  logic             vld_p [0:STAGES];

  // Result of resolving slice k on the contents of stage k.
  logic [WIDTH-1:0] d_nx   [0:STAGES-1];
  logic             brw_nx [0:STAGES-1];

  logic [WIDTH-1:0] d_o;
  logic             bout_o;
  logic             ovf_o;
  logic             zero_o;
  logic             vld_o;

  logic             stall;
  logic [WIDTH-1:0] d_fin;
  logic             ovf_fin;

  assign stall        = vld_o && !bus.ready_out;
  assign bus.ready_in = !stall;

  assign bus.d         = d_o;
  assign bus.bout      = bout_o;
  assign bus.ovf       = ovf_o;
  assign bus.zero      = zero_o;
  assign bus.valid_out = vld_o;

  // Resolve one slice per stage; already-resolved lower slices pass through.
  always_comb begin
    logic [SW:0] res;
    res = '0;
    for (int k = 0; k < STAGES; k++) begin
      res                    = slice_sub(a_p[k][SW*k +: SW], b_p[k][SW*k +: SW], brw_p[k]);
      d_nx[k]                = d_p[k];
      d_nx[k][SW*k +: SW]    = res[SW-1:0];
      brw_nx[k]              = res[SW];
    end
  end

  assign d_fin   = d_p[STAGES];
  assign ovf_fin = (a_p[STAGES][WIDTH-1] != b_p[STAGES][WIDTH-1]) &&
                   (d_fin[WIDTH-1] != a_p[STAGES][WIDTH-1]);

  // Stage registers: capture into stage 0, then shift one stage per cycle unless stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k <= STAGES; k++) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        d_p[k]   <= '0;
        brw_p[k] <= 1'b0;
        vld_p[k] <= 1'b0;
      end
    end else if (!stall) begin
      // ---- stage 0: operand capture ----
      a_p[0]   <= bus.a;
      b_p[0]   <= bus.b;
      d_p[0]   <= '0;
      brw_p[0] <= bus.bin;
      vld_p[0] <= bus.valid_in;
      // ---- stages 1..STAGES: one resolved slice further per stage ----
      for (int k = 0; k < STAGES; k++) begin
        a_p[k+1]   <= a_p[k];
        b_p[k+1]   <= b_p[k];
        d_p[k+1]   <= d_nx[k];
        brw_p[k+1] <= brw_nx[k];
        vld_p[k+1] <= vld_p[k];
      end
    end
  end

  // Output register: full difference, final borrow and flags; holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_o    <= '0;
      bout_o <= 1'b0;
      ovf_o  <= 1'b0;
      zero_o <= 1'b0;
      vld_o  <= 1'b0;
    end else if (!stall) begin
      // ---- output stage ----
      d_o    <= d_fin;
      bout_o <= brw_p[STAGES];
      ovf_o  <= ovf_fin;
      zero_o <= (d_fin == '0);
      vld_o  <= vld_p[STAGES];
    end
  end

endmodule

// File: tb/tb_pipelined_sequential_subtractor.sv
// Directed bench for pipelined_sequential_subtractor (WIDTH=32, STAGES=4).
module tb_pipelined_sequential_subtractor;

  localparam int W = 32;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  pipelined_sequential_subtractor_if #(.WIDTH(W)) bus ();

  pipelined_sequential_subtractor #(.WIDTH(W), .STAGES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, zero, bout, d} from plain wide arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    logic [W:0]   full;
    logic [W-1:0] d;
    logic         ov;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    d    = full[W-1:0];
    ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {ov, (d == '0), full[W], d};
  endfunction

  function automatic logic [W+2:0] observed();
    return {bus.ovf, bus.zero, bus.bout, bus.d};
  endfunction

  // Single op with ready_out=1; checks latency and the result word. Called at posedge+1.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic [W-1:0] ed, input logic eb,
                       input logic eo, input logic ez);
    int lat;
    bus.ready_out = 1'b1;
    bus.a = a; bus.b = b; bus.bin = bi; bus.valid_in = 1'b1;
    #1;
    check({tag, "_ready_in"}, {34'b0, bus.ready_in}, {34'b0, 1'b1});
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.valid_out) break;
    end
    check({tag, "_latency"}, (W+3)'(lat), (W+3)'(5));
    check({tag, "_result"}, observed(), {eo, ez, eb, ed});
    @(posedge clk); #1;
    check({tag, "_drained"}, {34'b0, bus.valid_out}, {34'b0, 1'b0});
  endtask

  initial begin
    logic [W+2:0] exp_q [$];
    logic [W+2:0] held;
    int           issued;
    int           got;
    int           cyc;
    int           seen;

    checks = 0; failures = 0;
    rstn = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.valid_in = 1'b0; bus.ready_out = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {observed(), 1'b0} >> 1, '0);
    check("rst_valid_out", {34'b0, bus.valid_out}, '0);
    check("rst_ready_in", {34'b0, bus.ready_in}, {34'b0, 1'b1});
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    do_op("t1_5m3",      32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    do_op("t2_0m1",      32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("t2_100m1",    32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    do_op("t3_minm1",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_op("t3_maxmneg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    do_op("t4_zero",     32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    do_op("t4_binonly",  32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // Stream of 10 ops with a 3-cycle output stall
    issued = 0; got = 0; cyc = 0;
    bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom_range(0, 1));
    held = '0;
    while (got < 10 && cyc < 200) begin
      bus.ready_out = !(cyc >= 7 && cyc <= 9);
      bus.valid_in  = (issued < 10);
      #1;
      if (!bus.ready_out) begin
        check("t5_stall_valid", {34'b0, bus.valid_out}, {34'b0, 1'b1});
        check("t5_stall_ready_in", {34'b0, bus.ready_in}, '0);
        if (cyc > 7) check("t5_stall_hold", observed(), held);
      end
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          check("t5_unexpected_result", {34'b0, 1'b1}, '0);
        end else begin
          check($sformatf("t5_res%0d", got), observed(), exp_q[0]);
          held = observed();
          if (bus.ready_out) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (bus.valid_in && bus.ready_in) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bin));
        issued++;
      end
      @(posedge clk); #1;
      if (bus.valid_in && issued > 0 && !$isunknown(bus.ready_in)) begin
        bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    bus.valid_in = 1'b0;
    check("t5_count", (W+3)'(got), (W+3)'(10));
    bus.ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_empty", {34'b0, bus.valid_out}, '0);

    // Async reset with 3 ops in flight, result parked in the output slot
    bus.ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.a = 32'h0000_1000 + i; bus.b = 32'h0000_0001; bus.bin = 1'b0; bus.valid_in = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.valid_out) break;
      @(posedge clk); #1;
    end
    check("t6_first_parked", observed(), model(32'h0000_1000, 32'h0000_0001, 1'b0));
    #2;
    rstn = 1'b0;
    #1;
    check("t6_async_outputs", observed(), '0);
    check("t6_async_valid", {34'b0, bus.valid_out}, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.ready_out = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out) seen++;
    end
    check("t6_no_ghost", (W+3)'(seen), '0);
    do_op("t6_after", 32'h0000_00A0, 32'h0000_000A, 1'b1, 32'h0000_0095, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
